peripheral_irq_controller: RTL and testbench

- Downstream consumer of the Peripherals block's 10-bit peripheral_irq vector (pwm[3:0], uart[3:0], gpio[1:0]).
- Per-source enable, level/rising-edge mode, sticky pending with write-1-to-clear, and fixed lowest-index-first priority.
- Produces a single registered core interrupt line plus the winning source index.
- Attaches to the shared peripheral bus as one more slave, muxed via requestOutput.

---
 rtl/peripheral_irq_controller.sv | 144 ++++++++++++++
 tb/tb_peripheral_irq_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_irq_controller.sv
// peripheral_irq_controller
//   Interrupt controller for the peripheral IRQ vector (pwm[3:0], uart[3:0],
//   gpio[1:0] by default). Each source has an enable bit and a level/edge
//   mode select. Pending bits are sticky with write-1-to-clear for edge
//   sources. The lowest-index active source wins. The block drives one
//   registered core interrupt line and the index of the winning source.
//
// Ports
//   wb_clk_i                  clock; the only clock
//   wb_rst_i                  synchronous active-high reset
//   peripheralBus_we/oe       write / read strobes
//   peripheralBus_busy        tied 0
//   peripheralBus_address     byte address; [23:12] selects the block, [11:0] is the offset
//   peripheralBus_byteSelect  write byte lanes
//   peripheralBus_dataWrite   write data
//   peripheralBus_dataRead    read data; 0 when the block is not selected
//   requestOutput             selected & oe, used by the top-level read mux
//   peripheral_irq            raw interrupt sources, synchronous to wb_clk_i
//   irq_out                   registered core interrupt
//   irq_id                    registered index of the winning active source
//
// Register map (offset)
//   0x00 ENABLE   rw
//   0x04 EDGE     rw, 1 = rising edge, 0 = level
//   0x08 PENDING  r, write 1 to clear (edge sources only)
//   0x0C ACTIVE   r, PENDING & ENABLE
//   0x10 CLAIM    r, bit31 = valid, [4:0] = lowest active index
//   0x14 CONTROL  rw, bit0 = global enable
module peripheral_irq_controller #(
  parameter logic [7:0]  ID      = 8'h04,
  parameter int unsigned SOURCES = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               peripheralBus_we,
  input  logic               peripheralBus_oe,
  output logic               peripheralBus_busy,
  input  logic [23:0]        peripheralBus_address,
  input  logic [3:0]         peripheralBus_byteSelect,
  input  logic [31:0]        peripheralBus_dataWrite,
  output logic [31:0]        peripheralBus_dataRead,
  output logic               requestOutput,
  input  logic [SOURCES-1:0] peripheral_irq,
  output logic               irq_out,
  output logic [4:0]         irq_id
);

  logic [SOURCES-1:0] r_enable;
  logic [SOURCES-1:0] r_edge;
  logic [SOURCES-1:0] r_pending;
  logic               r_control;
  logic [SOURCES-1:0] r_irq_s;
  logic [SOURCES-1:0] r_irq_d;
  logic               r_irq_out;
  logic [4:0]         r_irq_id;

  logic               w_sel;
  logic               w_wr;
  logic [11:0]        w_off;
  logic [31:0]        w_wmask;
  logic [SOURCES-1:0] w_lmask;
  logic [SOURCES-1:0] w_wdata_s;
  logic [SOURCES-1:0] w_clr;
  logic [SOURCES-1:0] w_rise;
  logic [SOURCES-1:0] w_active;
  logic [SOURCES-1:0] w_pend_next;
  logic               w_any;
  logic [4:0]         w_id;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_sel     = (peripheralBus_address[23:12] == {4'h0, ID});
  assign w_off     = peripheralBus_address[11:0];
  assign w_wr      = peripheralBus_we & w_sel;
  assign w_wmask   = {{8{peripheralBus_byteSelect[3]}}, {8{peripheralBus_byteSelect[2]}},
                      {8{peripheralBus_byteSelect[1]}}, {8{peripheralBus_byteSelect[0]}}};
  assign w_lmask   = w_wmask[SOURCES-1:0];
  assign w_wdata_s = peripheralBus_dataWrite[SOURCES-1:0];

  // Bits above SOURCES-1 and unused byte lanes carry no state.
  assign w_unused  = ^{peripheralBus_dataWrite, w_wmask};

  assign w_clr  = (w_wr && (w_off == 12'h008)) ? (w_wdata_s & w_lmask) : '0;
  assign w_rise = r_irq_s & ~r_irq_d;

  // Edge sources are sticky (a new rise beats a same-cycle clear); level
  // sources simply follow the synchronised input.
  assign w_pend_next = (r_edge & (w_rise | (r_pending & ~w_clr))) | (~r_edge & r_irq_s);

  assign w_active = r_pending & r_enable;
  assign w_any    = |w_active;

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    w_id = '0;
    for (int unsigned i = SOURCES; i > 0; i--) begin
      if (w_active[i-1]) w_id = 5'(i - 1);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_off)
        12'h000: w_rdata = 32'(r_enable);
        12'h004: w_rdata = 32'(r_edge);
        12'h008: w_rdata = 32'(r_pending);
        12'h00C: w_rdata = 32'(w_active);
        12'h010: w_rdata = {w_any, 26'd0, w_id};
        12'h014: w_rdata = {31'd0, r_control};
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_enable  <= '0;
      r_edge    <= '0;
      r_pending <= '0;
      r_control <= 1'b0;
      r_irq_s   <= '0;
      r_irq_d   <= '0;
      r_irq_out <= 1'b0;
      r_irq_id  <= '0;
    end else begin
      r_irq_s   <= peripheral_irq;
      r_irq_d   <= r_irq_s;
      r_pending <= w_pend_next;
      r_irq_out <= r_control & w_any;
      r_irq_id  <= w_id;
      if (w_wr && (w_off == 12'h000)) r_enable <= (r_enable & ~w_lmask) | (w_wdata_s & w_lmask);
      if (w_wr && (w_off == 12'h004)) r_edge   <= (r_edge & ~w_lmask) | (w_wdata_s & w_lmask);
      if (w_wr && (w_off == 12'h014) && peripheralBus_byteSelect[0]) r_control <= peripheralBus_dataWrite[0];
    end
  end

  assign peripheralBus_busy     = 1'b0;
  assign peripheralBus_dataRead = w_rdata;
  assign requestOutput          = peripheralBus_oe & w_sel;
  assign irq_out                = r_irq_out;
  assign irq_id                 = r_irq_id;

endmodule

// File: tb/tb_peripheral_irq_controller.sv
module tb_peripheral_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, oe;
  logic        busy;
  logic [23:0] addr;
  logic [3:0]  bs;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        req;
  logic [9:0]  irq;
  logic        irq_out;
  logic [4:0]  irq_id;

  int checks   = 0;
  int failures = 0;

  localparam logic [11:0] BASE = 12'h004;

  peripheral_irq_controller #(.ID(8'h04), .SOURCES(10)) dut (
    .wb_clk_i                 (clk),
    .wb_rst_i                 (rst),
    .peripheralBus_we         (we),
    .peripheralBus_oe         (oe),
    .peripheralBus_busy       (busy),
    .peripheralBus_address    (addr),
    .peripheralBus_byteSelect (bs),
    .peripheralBus_dataWrite  (wdata),
    .peripheralBus_dataRead   (rdata),
    .requestOutput            (req),
    .peripheral_irq           (irq),
    .irq_out                  (irq_out),
    .irq_id                   (irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] off;
    logic [31:0] exp;
  } rvec_t;

  typedef struct {
    logic [3:0]  bs;
    logic [31:0] data;
    logic [31:0] exp;
  } wvec_t;

  rvec_t rtab[7];
  wvec_t wtab[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] off, input logic [3:0] lanes, input logic [31:0] d);
    addr  = {BASE, off};
    bs    = lanes;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    bs    = 4'h0;
    wdata = '0;
  endtask

  task automatic rd(input logic [11:0] off, output logic [31:0] d);
    addr = {BASE, off};
    oe   = 1'b1;
    #1;
    d    = rdata;
    oe   = 1'b0;
  endtask

  task automatic rdchk(input string nm, input logic [11:0] off, input logic [31:0] exp);
    logic [31:0] d;
    rd(off, d);
    chk(nm, d, exp);
  endtask

  initial begin
    logic [31:0] d;

    rtab[0] = '{"rst_enable",  12'h000, 32'h0};
    rtab[1] = '{"rst_edge",    12'h004, 32'h0};
    rtab[2] = '{"rst_pending", 12'h008, 32'h0};
    rtab[3] = '{"rst_active",  12'h00C, 32'h0};
    rtab[4] = '{"rst_claim",   12'h010, 32'h0};
    rtab[5] = '{"rst_control", 12'h014, 32'h0};
    rtab[6] = '{"rst_other",   12'h018, 32'h0};

    // ENABLE starts at 0; lane-masked writes accumulate.
    wtab[0] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0300};
    wtab[1] = '{4'b0001, 32'h0000_00A5, 32'h0000_03A5};
    wtab[2] = '{4'b1100, 32'hFFFF_FFFF, 32'h0000_03A5};
    wtab[3] = '{4'b0011, 32'h0000_0000, 32'h0000_0000};

    rst = 1'b1; we = 1'b0; oe = 1'b0; addr = 24'h005000; bs = 4'h0; wdata = '0; irq = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    foreach (rtab[i]) rdchk(rtab[i].name, rtab[i].off, rtab[i].exp);
    chk("rst_irq_out", 32'(irq_out), 32'h0);
    chk("rst_irq_id", 32'(irq_id), 32'h0);
    addr = 24'h005000; oe = 1'b1; #1;
    chk("unsel_req", 32'(req), 32'h0);
    chk("unsel_rdata", rdata, 32'h0);
    addr = {BASE, 12'h000}; #1;
    chk("sel_req", 32'(req), 32'h1);
    chk("busy", 32'(busy), 32'h0);
    oe = 1'b0;

    // Edge source 0: pulse, latency, claim, W1C
    wr(12'h000, 4'hF, 32'h0000_03FF);
    wr(12'h004, 4'hF, 32'h0000_0001);
    wr(12'h014, 4'hF, 32'h0000_0001);
    irq = 10'h001;
    tick();
    irq = 10'h000;
    rdchk("e0_pend_k", 12'h008, 32'h0);
    tick();
    rdchk("e0_pend_k1", 12'h008, 32'h1);
    chk("e0_irq_k1", 32'(irq_out), 32'h0);
    tick();
    chk("e0_irq_k2", 32'(irq_out), 32'h1);
    chk("e0_id", 32'(irq_id), 32'h0);
    rdchk("e0_claim", 12'h010, 32'h8000_0000);
    tick();
    rdchk("e0_pend_sticky", 12'h008, 32'h1);
    wr(12'h008, 4'hF, 32'h0000_0001);
    rdchk("e0_pend_clr", 12'h008, 32'h0);
    chk("e0_irq_hold", 32'(irq_out), 32'h1);
    tick();
    chk("e0_irq_clr", 32'(irq_out), 32'h0);

    // Level source 5
    irq = 10'h020;
    tick(); tick();
    rdchk("l5_pend", 12'h008, 32'h020);
    tick();
    chk("l5_id", 32'(irq_id), 32'h5);
    wr(12'h008, 4'hF, 32'h0000_0020);
    rdchk("l5_w1c_noeffect", 12'h008, 32'h020);
    irq = 10'h000;
    tick();
    rdchk("l5_drop_1", 12'h008, 32'h020);
    tick();
    rdchk("l5_drop_2", 12'h008, 32'h0);

    // Priority between sources 3 and 7 (level)
    irq = 10'h088;
    wr(12'h000, 4'hF, 32'h0000_0080);
    tick(); tick();
    chk("pri_id7", 32'(irq_id), 32'h7);
    rdchk("pri_claim7", 12'h010, 32'h8000_0007);
    rdchk("pri_active", 12'h00C, 32'h080);
    wr(12'h000, 4'hF, 32'h0000_0088);
    rdchk("pri_claim3", 12'h010, 32'h8000_0003);
    tick();
    chk("pri_id3", 32'(irq_id), 32'h3);
    irq = 10'h000;
    tick(); tick(); tick();
    rdchk("pri_claim_none", 12'h010, 32'h0);
    chk("pri_id_none", 32'(irq_id), 32'h0);
    chk("pri_irq_none", 32'(irq_out), 32'h0);

    // Edge source 2: clear coinciding with a new rise keeps the bit set
    wr(12'h004, 4'hF, 32'h0000_0005);
    irq = 10'h004;
    tick();
    irq = 10'h000;
    tick();
    rdchk("e2_pend", 12'h008, 32'h004);
    irq = 10'h004;
    tick();
    irq = 10'h000;
    wr(12'h008, 4'hF, 32'h0000_0004);
    rdchk("e2_set_wins", 12'h008, 32'h004);
    wr(12'h008, 4'hF, 32'h0000_0004);
    rdchk("e2_clr", 12'h008, 32'h0);
    wr(12'h008, 4'b1110, 32'h0000_0004);
    rdchk("e2_clr_lane_masked", 12'h008, 32'h0);

    // Byte-lane masked ENABLE writes
    wr(12'h000, 4'hF, 32'h0);
    foreach (wtab[i]) begin
      wr(12'h000, wtab[i].bs, wtab[i].data);
      rdchk($sformatf("lane_%0d", i), 12'h000, wtab[i].exp);
    end

    // Global enable gates irq_out but not ACTIVE/irq_id
    wr(12'h000, 4'hF, 32'h0000_03FF);
    wr(12'h014, 4'hF, 32'h0);
    irq = 10'h020;
    tick(); tick(); tick();
    rdchk("ge_active", 12'h00C, 32'h020);
    chk("ge_irq_off", 32'(irq_out), 32'h0);
    chk("ge_id", 32'(irq_id), 32'h5);
    wr(12'h014, 4'hF, 32'h1);
    tick();
    chk("ge_irq_on", 32'(irq_out), 32'h1);

    // Reset in the middle of a write discards it
    addr = {BASE, 12'h004}; bs = 4'hF; wdata = 32'h0000_00FF; we = 1'b1;
    rst = 1'b1;
    tick();
    we = 1'b0; rst = 1'b0;
    rdchk("mr_enable", 12'h000, 32'h0);
    rdchk("mr_edge", 12'h004, 32'h0);
    rdchk("mr_pending", 12'h008, 32'h0);
    rdchk("mr_control", 12'h014, 32'h0);
    chk("mr_irq_out", 32'(irq_out), 32'h0);
    chk("mr_irq_id", 32'(irq_id), 32'h0);
    tick();
    rdchk("mr_level_pend_1", 12'h008, 32'h0);
    tick();
    rdchk("mr_level_pend_2", 12'h008, 32'h020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
